// File: rtl/perf_counter_sampler.sv
// Avalon-MM master that turns START/STOP/SAMPLE/CLEAR_ALL commands into accesses on the
// performance-counter slave. Define PERF_SAMPLER_COHERENT_EN for the untorn hi/lo/hi2 sample.
module perf_counter_sampler #(
    parameter int NUM_SECTIONS = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_section,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_time,
    output logic [31:0] res_events,
    output logic        res_err,
    output logic        busy,
    output logic [3:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RESULT} state_t;
    typedef enum logic [1:0] {OP_START, OP_STOP, OP_SAMPLE, OP_CLEAR_ALL} op_t;
    typedef enum logic [1:0] {W_LO, W_HI, W_HI2, W_EV} word_t;

`ifdef PERF_SAMPLER_COHERENT_EN
    localparam word_t FIRST_WORD = W_HI;
`else
    localparam word_t FIRST_WORD = W_LO;
`endif

    state_t     state, state_nxt;
    word_t      word, word_nxt;
    op_t        op;
    logic [1:0] sec;
    logic [1:0] lat_cnt;
    logic       last_word;
    logic       cmd_fire;
    logic       sec_bad;
    logic       rd_done;
`ifdef PERF_SAMPLER_COHERENT_EN
    logic [1:0] retry_cnt;
    logic       hi_torn;
`endif

    function automatic logic [3:0] word_addr(input logic [1:0] s, input word_t w);
        case (w)
            W_LO:    return {s, 2'b00};
            W_EV:    return {s, 2'b10};
            default: return {s, 2'b01};
        endcase
    endfunction

    assign op       = op_t'(cmd_op);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign sec_bad  = int'(cmd_section) >= NUM_SECTIONS;
    assign rd_done  = (state == RD_WAIT) && (lat_cnt == 2'(READ_LATENCY - 1));

    // Read order: lo, hi, events; the coherent build reads hi, lo, hi2 (repeat lo/hi2 on carry), events.
    always_comb begin
        word_nxt  = word;
        last_word = 1'b0;
`ifdef PERF_SAMPLER_COHERENT_EN
        hi_torn = (word == W_HI2) && (avm_readdata != res_time[63:32]);
        case (word)
            W_HI:    word_nxt = W_LO;
            W_LO:    word_nxt = W_HI2;
            W_HI2:   word_nxt = (hi_torn && retry_cnt != 2'd3) ? W_LO : W_EV;
            default: last_word = 1'b1;
        endcase
`else
        case (word)
            W_LO:    word_nxt = W_HI;
            W_HI:    word_nxt = W_EV;
            default: last_word = 1'b1;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (op == OP_CLEAR_ALL) state_nxt = WRITE;
                    else if (sec_bad)       state_nxt = (op == OP_SAMPLE) ? RESULT : IDLE;
                    else                    state_nxt = (op == OP_SAMPLE) ? RD_REQ : WRITE;
                end
            end
            WRITE:   if (!avm_waitrequest) state_nxt = IDLE;
            RD_REQ:  if (!avm_waitrequest) state_nxt = RD_WAIT;
            RD_WAIT: if (rd_done)          state_nxt = last_word ? RESULT : RD_REQ;
            RESULT:  if (res_ready)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: cmd_ready is masked by reset so no command can be accepted while reset is sampled.
    always_comb begin
        res_valid = (state == RESULT);
        cmd_ready = (state == IDLE) && !res_valid && !reset;
        busy      = (state != IDLE);
        avm_write = (state == WRITE);
        avm_read  = (state == RD_REQ);
    end

    // NOTE: every register here uses non-blocking assignment so the case arms see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            word          <= FIRST_WORD;
            sec           <= 2'd0;
            lat_cnt       <= 2'd0;
            avm_address   <= 4'h0;
            avm_writedata <= 32'h0;
            res_time      <= 64'h0;
            res_events    <= 32'h0;
            res_err       <= 1'b0;
`ifdef PERF_SAMPLER_COHERENT_EN
            retry_cnt     <= 2'd0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        sec           <= cmd_section;
                        word          <= FIRST_WORD;
                        avm_writedata <= 32'h0;
`ifdef PERF_SAMPLER_COHERENT_EN
                        retry_cnt     <= 2'd0;
`endif
                        case (op)
                            OP_START: avm_address <= {cmd_section, 2'b01};
                            OP_STOP:  avm_address <= {cmd_section, 2'b00};
                            OP_SAMPLE: begin
                                avm_address <= word_addr(cmd_section, FIRST_WORD);
                                res_err     <= sec_bad;
                                if (sec_bad) begin
                                    res_time   <= 64'h0;
                                    res_events <= 32'h0;
                                end
                            end
                            default: begin
                                avm_address   <= 4'h0;
                                avm_writedata <= 32'h1;
                            end
                        endcase
                    end
                end
                RD_REQ: lat_cnt <= 2'd0;
                RD_WAIT: begin
                    if (rd_done) begin
                        case (word)
                            W_LO:    res_time[31:0]  <= avm_readdata;
                            W_EV:    res_events      <= avm_readdata;
                            default: res_time[63:32] <= avm_readdata;
                        endcase
                        word        <= word_nxt;
                        avm_address <= word_addr(sec, word_nxt);
`ifdef PERF_SAMPLER_COHERENT_EN
                        if (hi_torn) begin
                            if (retry_cnt == 2'd3) res_err   <= 1'b1;
                            else                   retry_cnt <= retry_cnt + 2'd1;
                        end
`endif
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Bench for perf_counter_sampler: a command table run against a counter-slave model,
// plus reset, invalid-section (NUM_SECTIONS=2 instance) and lo->hi carry sequences.
module tb_perf_counter_sampler;

    localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_SAMPLE = 2'd2, OP_CLEAR = 2'd3;
`ifdef PERF_SAMPLER_COHERENT_EN
    localparam int          NREADS     = 4;
    localparam logic [63:0] CARRY_TIME = 64'h0000_0001_0000_0002;
    localparam int          CARRY_LAT  = 13;
`else
    localparam int          NREADS     = 3;
    localparam logic [63:0] CARRY_TIME = 64'h0000_0000_FFFF_FFFF;
    localparam int          CARRY_LAT  = 7;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sec;
        int          stall;
        logic        load;
        logic [31:0] lo, hi, ev;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [63:0] etime;
        logic [31:0] eev;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0, res_err, busy;
    logic [1:0]  cmd_op = 2'd0, cmd_section = 2'd0;
    logic [63:0] res_time;
    logic [31:0] res_events, avm_writedata, avm_readdata = 32'h0;
    logic [3:0]  avm_address;
    logic        avm_write, avm_read, avm_waitrequest;

    logic        b_cmd_valid = 1'b0, b_cmd_ready, b_res_valid, b_res_ready = 1'b0, b_res_err, b_busy;
    logic [1:0]  b_cmd_op = 2'd0, b_cmd_section = 2'd0;
    logic [63:0] b_res_time;
    logic [31:0] b_res_events, b_avm_writedata, b_avm_readdata;
    logic [3:0]  b_avm_address;
    logic        b_avm_write, b_avm_read, b_avm_waitrequest;

    assign b_avm_waitrequest = 1'b0;
    assign b_avm_readdata    = 32'h0;

    always #5 clk = ~clk;

    perf_counter_sampler #(.NUM_SECTIONS(4), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_section(cmd_section), .res_valid(res_valid), .res_ready(res_ready), .res_time(res_time),
        .res_events(res_events), .res_err(res_err), .busy(busy), .avm_address(avm_address),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    perf_counter_sampler #(.NUM_SECTIONS(2), .READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
        .cmd_section(b_cmd_section), .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_time(b_res_time), .res_events(b_res_events), .res_err(b_res_err), .busy(b_busy),
        .avm_address(b_avm_address), .avm_write(b_avm_write), .avm_read(b_avm_read),
        .avm_writedata(b_avm_writedata), .avm_waitrequest(b_avm_waitrequest),
        .avm_readdata(b_avm_readdata)
    );

    // Counter slave model: word memory, programmable stall per request, read latency 1.
    logic [31:0] mem [16] = '{default: 32'h0};
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = 4'h0;
    logic [31:0] ld_data = 32'h0;
    int          stall_cfg = 0, stall_cnt = 0;
    int          rd_count = 0, wr_count = 0, wr_hold = 0, last_hold = 0;
    logic [3:0]  last_waddr = 4'h0;
    logic [31:0] last_wdata = 32'h0;
    int          upd_at = -1;
    logic [1:0]  upd_sec = 2'd0;
    logic [31:0] upd_lo = 32'h0, upd_hi = 32'h0;
    int          bus_viol = 0, b_bus_cycles = 0;
    logic        prev_pend = 1'b0;
    logic [3:0]  prev_addr = 4'h0;
    logic [31:0] prev_data = 32'h0;
    logic [1:0]  prev_req = 2'b00;

    assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < stall_cfg);

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (b_avm_read || b_avm_write) b_bus_cycles <= b_bus_cycles + 1;
        if (reset) begin
            stall_cnt <= 0;
            wr_hold   <= 0;
            prev_pend <= 1'b0;
        end else begin
            stall_cnt <= avm_waitrequest ? stall_cnt + 1 : 0;
            prev_pend <= avm_waitrequest;
            prev_addr <= avm_address;
            prev_data <= avm_writedata;
            prev_req  <= {avm_read, avm_write};
            if (avm_read && avm_write)
                bus_viol <= bus_viol + 1;
            else if (prev_pend && (avm_address != prev_addr || avm_writedata != prev_data ||
                                   {avm_read, avm_write} != prev_req))
                bus_viol <= bus_viol + 1;
            if (avm_write) begin
                if (avm_waitrequest) begin
                    wr_hold <= wr_hold + 1;
                end else begin
                    wr_count   <= wr_count + 1;
                    last_waddr <= avm_address;
                    last_wdata <= avm_writedata;
                    last_hold  <= wr_hold + 1;
                    wr_hold    <= 0;
                    if (avm_address == 4'h0 && avm_writedata == 32'h1)
                        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
                end
            end
            if (avm_read && !avm_waitrequest) begin
                avm_readdata <= mem[avm_address];
                rd_count     <= rd_count + 1;
                if (rd_count + 1 == upd_at) begin
                    mem[{upd_sec, 2'b00}] <= upd_lo;
                    mem[{upd_sec, 2'b01}] <= upd_hi;
                end
            end
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sec);
        int n = 0;
        @(negedge clk);
        cmd_op      = op;
        cmd_section = sec;
        cmd_valid   = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready at issue", 64'(cmd_ready), 64'h1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 300);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check("write completes", 64'(busy), 64'h0);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("res_valid drops after handshake", 64'({res_valid, cmd_ready}), 64'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [9];
    vec_t v;
    int   lat, w0, n;

    initial begin
        vecs[0] = '{op: OP_START,  sec: 2'd1, stall: 2, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd5, wdata: 32'h0, etime: 64'h0, eev: 32'h0};
        vecs[1] = '{op: OP_STOP,   sec: 2'd1, stall: 2, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd4, wdata: 32'h0, etime: 64'h0, eev: 32'h0};
        vecs[2] = '{op: OP_SAMPLE, sec: 2'd2, stall: 0, load: 1'b1, lo: 32'h0000_0100, hi: 32'h1, ev: 32'h7,
                    waddr: 4'd0, wdata: 32'h0, etime: 64'h0000_0001_0000_0100, eev: 32'h7};
        vecs[3] = '{op: OP_CLEAR,  sec: 2'd2, stall: 0, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd0, wdata: 32'h1, etime: 64'h0, eev: 32'h0};
        vecs[4] = '{op: OP_SAMPLE, sec: 2'd3, stall: 0, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd0, wdata: 32'h0, etime: 64'h0, eev: 32'h0};
        vecs[5] = '{op: OP_START,  sec: 2'd0, stall: 1, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd1, wdata: 32'h0, etime: 64'h0, eev: 32'h0};
        vecs[6] = '{op: OP_SAMPLE, sec: 2'd0, stall: 1, load: 1'b1, lo: 32'hFFFF_FFFF, hi: 32'h0000_ABCD,
                    ev: 32'h1234_5678, waddr: 4'd0, wdata: 32'h0, etime: 64'h0000_ABCD_FFFF_FFFF,
                    eev: 32'h1234_5678};
        vecs[7] = '{op: OP_SAMPLE, sec: 2'd1, stall: 0, load: 1'b1, lo: 32'hDEAD_BEEF, hi: 32'h8000_0000,
                    ev: 32'hFFFF_FFFF, waddr: 4'd0, wdata: 32'h0, etime: 64'h8000_0000_DEAD_BEEF,
                    eev: 32'hFFFF_FFFF};
        vecs[8] = '{op: OP_STOP,   sec: 2'd3, stall: 0, load: 1'b0, lo: 32'h0, hi: 32'h0, ev: 32'h0,
                    waddr: 4'd12, wdata: 32'h0, etime: 64'h0, eev: 32'h0};

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl outputs", 64'({cmd_ready, res_valid, res_err, busy, avm_write, avm_read, avm_address}), 64'h0);
        check("reset res_time", res_time, 64'h0);
        check("reset res_events/writedata", 64'({res_events, avm_writedata}), 64'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", 64'({cmd_ready, busy, res_valid}), 64'h4);

        // Section 3 holds non-zero counts so CLEAR_ALL has something to wipe.
        poke(4'd12, 32'h11);
        poke(4'd13, 32'h22);
        poke(4'd14, 32'h33);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            if (v.load) begin
                poke({v.sec, 2'b00}, v.lo);
                poke({v.sec, 2'b01}, v.hi);
                poke({v.sec, 2'b10}, v.ev);
            end
            stall_cfg = v.stall;
            w0        = wr_count;
            res_ready = (v.op != OP_SAMPLE);
            issue(v.op, v.sec);
            if (v.op == OP_SAMPLE) begin
                wait_res(lat);
                check($sformatf("v%0d latency", i), 64'(lat), 64'(NREADS * (v.stall + 2) + 1));
                check($sformatf("v%0d res_time", i), res_time, v.etime);
                check($sformatf("v%0d res_events/err", i), 64'({res_events, res_err}), 64'({v.eev, 1'b0}));
                check($sformatf("v%0d no writes", i), 64'(wr_count - w0), 64'h0);
                consume();
            end else begin
                wait_idle();
                check($sformatf("v%0d write count", i), 64'(wr_count - w0), 64'h1);
                check($sformatf("v%0d write addr/data", i), 64'({last_waddr, last_wdata}), 64'({v.waddr, v.wdata}));
                check($sformatf("v%0d write hold", i), 64'(last_hold), 64'(v.stall + 1));
                check($sformatf("v%0d no result", i), 64'(res_valid), 64'h0);
                res_ready = 1'b0;
            end
        end

        // Reset while a read is stalled: request dropped, result registers cleared.
        stall_cfg = 1000;
        issue(OP_SAMPLE, 2'd2);
        repeat (3) @(negedge clk);
        check("T1 read pending", 64'({busy, avm_read}), 64'h3);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("T1 ctrl zero %0d", k),
                  64'({cmd_ready, res_valid, res_err, busy, avm_write, avm_read, avm_address}), 64'h0);
            check($sformatf("T1 res_time zero %0d", k), res_time, 64'h0);
            check($sformatf("T1 events/wdata zero %0d", k), 64'({res_events, avm_writedata}), 64'h0);
        end
        reset     = 1'b0;
        stall_cfg = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("T1 no partial result %0d", k), 64'({res_valid, busy, cmd_ready}), 64'h1);
        end

        // Invalid section on the two-section instance.
        b_res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("T5 res_ready while idle", 64'({b_res_valid, b_cmd_ready}), 64'h1);
        b_res_ready   = 1'b0;
        b_cmd_op      = OP_SAMPLE;
        b_cmd_section = 2'd3;
        b_cmd_valid   = 1'b1;
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_res_valid && n < 20);
        check("T5 res_valid", 64'(b_res_valid), 64'h1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("T5 hold ctrl %0d", k), 64'({b_res_valid, b_res_err, b_cmd_ready, b_busy}), 64'hD);
            check($sformatf("T5 hold data %0d", k), b_res_time | 64'(b_res_events), 64'h0);
            @(negedge clk);
        end
        b_res_ready = 1'b1;
        @(posedge clk);
        #1 b_res_ready = 1'b0;
        @(negedge clk);
        check("T5 released", 64'({b_res_valid, b_cmd_ready, b_busy}), 64'h2);
        b_cmd_op      = OP_START;
        b_cmd_section = 2'd2;
        b_cmd_valid   = 1'b1;
        @(posedge clk);
        #1 b_cmd_valid = 1'b0;
        @(negedge clk);
        check("T5 bad START consumed", 64'({b_busy, b_cmd_ready, b_res_valid}), 64'h2);
        check("T5 no bus activity", 64'(b_bus_cycles), 64'h0);

        // Counter carries from lo into hi after the second read of the sample.
        poke(4'd4, 32'hFFFF_FFFF);
        poke(4'd5, 32'h0);
        poke(4'd6, 32'h5);
        upd_sec = 2'd1;
        upd_lo  = 32'h2;
        upd_hi  = 32'h1;
        upd_at  = rd_count + 2;
        issue(OP_SAMPLE, 2'd1);
        wait_res(lat);
        check("T6 latency", 64'(lat), 64'(CARRY_LAT));
        check("T6 res_time", res_time, CARRY_TIME);
        check("T6 res_events/err", 64'({res_events, res_err}), 64'({32'h5, 1'b0}));
        consume();
        upd_at = -1;

        check("bus protocol violations", 64'(bus_viol), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
